// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the ADXL345 SPI host master:
//   state_e     - controller FSM states
//   RW_BIT      - request frame bit selecting read (1) or write (0)
//   MB_BIT      - request frame multi-byte bit
//   ADDR_MSB/LSB- register address field inside the request frame
//   FRAME_BITS  - number of SCLK periods per transaction
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ACK   = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    localparam int RW_BIT     = 15;
    localparam int MB_BIT     = 14;
    localparam int ADDR_MSB   = 13;
    localparam int ADDR_LSB   = 8;
    localparam int FRAME_BITS = 16;

endpackage

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// SCLK phase generator. While en is high it walks through one SCLK period of
// 2*CLK_DIV clk cycles and flags the cycles whose closing clk edge must move
// SCLK. With en low the phase counter is held at zero, so every period starts
// aligned to the cycle in which en rises.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   en         - run the phase counter
//   sclk_rise  - one-cycle strobe: the coming edge drives SCLK 0->1
//   sclk_fall  - one-cycle strobe: the coming edge drives SCLK 1->0
// -----------------------------------------------------------------------------
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int CNT_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FALL_AT = CNT_W'(2 * CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == FALL_AT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sclk_rise = en && (cnt_q == RISE_AT);
    assign sclk_fall = en && (cnt_q == FALL_AT);

endmodule

// File: rtl/spi_host_master.sv
// -----------------------------------------------------------------------------
// spi_host_master
// Turns one 16-bit host request into one SPI mode-3 transaction (MSB first,
// cs_n framed) towards the ADXL345, and returns the last byte shifted in with
// a one-cycle acknowledge.
// Optional build macro: SPI_3WIRE_EN adds spi_mosi_oe for a shared SDIO line.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   host_req        - request, held until host_ack
//   host_req_data   - frame {R/W, MB, addr[5:0], wdata[7:0]}
//   host_ack        - one-cycle done pulse
//   host_ack_data   - received byte, valid with host_ack and held afterwards
//   spi_cs_n        - chip select, active-low
//   spi_sclk        - serial clock, idles high
//   spi_mosi        - serial data out
//   spi_mosi_oe     - (SPI_3WIRE_EN only) output enable for the SDIO driver
//   spi_miso        - serial data in (SDIO input in 3-wire builds)
// Handshake: a frame is accepted in the first IDLE cycle with host_req high;
// host_req_data is only sampled in that cycle. host_ack pulses once per
// accepted frame; host_req is ignored until the post-frame gap has elapsed.
// All SPI pins come straight from flops.
// -----------------------------------------------------------------------------
module spi_host_master
    import spi_pkg::*;
#(
    parameter int REQ_DATA_WIDTH = 16,
    parameter int ACK_DATA_WIDTH = 8,
    parameter int CLK_DIV        = 2,
    parameter int CS_SETUP       = 1,
    parameter int CS_HOLD        = 1,
    parameter int CS_IDLE        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      host_req,
    input  logic [REQ_DATA_WIDTH-1:0] host_req_data,
    output logic                      host_ack,
    output logic [ACK_DATA_WIDTH-1:0] host_ack_data,
    output logic                      spi_cs_n,
    output logic                      spi_sclk,
    output logic                      spi_mosi,
`ifdef SPI_3WIRE_EN
    output logic                      spi_mosi_oe,
`endif
    input  logic                      spi_miso
);

    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

    state_e                      state_q, state_d;
    logic [15:0]                 wait_q, wait_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic [REQ_DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [ACK_DATA_WIDTH-1:0]   rx_q, rx_d;
    logic                        cs_n_q, cs_n_d;
    logic                        sclk_q, sclk_d;
    logic                        mosi_q, mosi_d;
    logic                        ack_q, ack_d;
    logic [ACK_DATA_WIDTH-1:0]   ack_data_q, ack_data_d;
`ifdef SPI_3WIRE_EN
    logic                        oe_q, oe_d;
    logic                        rw_q, rw_d;
`endif

    logic div_en;
    logic sclk_rise;
    logic sclk_fall;

    // The divider only runs in SHIFT; the first falling edge of a frame is
    // produced by the SETUP->SHIFT transition itself, the rest by the strobes.
    assign div_en = (state_q == ST_SHIFT);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (div_en),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ack_d      = 1'b0;
        ack_data_d = ack_data_q;
`ifdef SPI_3WIRE_EN
        oe_d       = oe_q;
        rw_d       = rw_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    tx_d    = host_req_data;
                    cs_n_d  = 1'b0;
                    wait_d  = '0;
                    bit_d   = '0;
                    state_d = ST_SETUP;
`ifdef SPI_3WIRE_EN
                    rw_d    = host_req_data[RW_BIT];
`endif
                end
            end
            ST_SETUP: begin
                if (wait_q == SETUP_LAST) begin
                    sclk_d  = 1'b0;
                    mosi_d  = tx_q[REQ_DATA_WIDTH-1];
                    state_d = ST_SHIFT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[ACK_DATA_WIDTH-2:0], spi_miso};
                end
                if (sclk_fall) begin
                    if (bit_q == LAST_BIT) begin
                        // Bit 16 ends with SCLK left high.
                        wait_d  = '0;
                        state_d = ST_HOLD;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[REQ_DATA_WIDTH-2];
                        sclk_d = 1'b0;
`ifdef SPI_3WIRE_EN
                        // Leaving bit index 7 is the 9th falling edge: the
                        // slave owns SDIO for the data byte of a read.
                        if (rw_q && (bit_q == BIT_W'(7))) begin
                            oe_d = 1'b0;
                        end
`endif
                    end
                end
            end
            ST_HOLD: begin
                if (wait_q == HOLD_LAST) begin
                    ack_d      = 1'b1;
                    ack_data_d = rx_q;
                    cs_n_d     = 1'b1;
                    state_d    = ST_ACK;
`ifdef SPI_3WIRE_EN
                    oe_d       = 1'b1;
`endif
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_ACK: begin
                wait_d  = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                // host_req is deliberately not looked at here.
                if (wait_q == IDLE_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            ack_q      <= 1'b0;
            ack_data_q <= '0;
`ifdef SPI_3WIRE_EN
            oe_q       <= 1'b1;
            rw_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ack_q      <= ack_d;
            ack_data_q <= ack_data_d;
`ifdef SPI_3WIRE_EN
            oe_q       <= oe_d;
            rw_q       <= rw_d;
`endif
        end
    end

    assign host_ack      = ack_q;
    assign host_ack_data = ack_data_q;
    assign spi_cs_n      = cs_n_q;
    assign spi_sclk      = sclk_q;
    assign spi_mosi      = mosi_q;
`ifdef SPI_3WIRE_EN
    assign spi_mosi_oe   = oe_q;
`endif

endmodule

// File: tb/tb_spi_host_master.sv
// -----------------------------------------------------------------------------
// tb_spi_host_master
// Directed and randomized frames against spi_host_master. A slave model inside
// the bench answers on SCLK falling edges; expected bytes, latencies and bit
// streams are derived from the frame format and timing parameters.
// -----------------------------------------------------------------------------
module tb_spi_host_master;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 1;
    localparam int CS_HOLD  = 1;
    localparam int CS_IDLE  = 2;
    // Cycles from request acceptance (T0) to host_ack.
    localparam int LAT = CS_SETUP + 32 * CLK_DIV + CS_HOLD + 1;

    logic        clk;
    logic        rst;
    logic        host_req;
    logic [15:0] host_req_data;
    logic        host_ack;
    logic [7:0]  host_ack_data;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
`ifdef SPI_3WIRE_EN
    logic        spi_mosi_oe;
`endif

    spi_host_master #(
        .REQ_DATA_WIDTH (16),
        .ACK_DATA_WIDTH (8),
        .CLK_DIV        (CLK_DIV),
        .CS_SETUP       (CS_SETUP),
        .CS_HOLD        (CS_HOLD),
        .CS_IDLE        (CS_IDLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_req      (host_req),
        .host_req_data (host_req_data),
        .host_ack      (host_ack),
        .host_ack_data (host_ack_data),
        .spi_cs_n      (spi_cs_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
`ifdef SPI_3WIRE_EN
        .spi_mosi_oe   (spi_mosi_oe),
`endif
        .spi_miso      (spi_miso)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    int          cyc = 0;
    logic        prev_sclk = 1'b1;
    logic        prev_cs = 1'b1;
    logic        prev_oe = 1'b1;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          miso_idx = 0;
    int          cs_low_cnt = 0;
    int          cs_high_run = 0;
    int          gap_at_fall = 0;
    int          fall_cyc = 0;
    int          sclk_edges = 0;
    int          oe_fall_num = 0;
    int          oe_rise_cyc = -1;
    logic [15:0] mosi_cap = '0;
    logic [15:0] slave_word = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: byte returned is the last 8 bits on the data-in line.
    function automatic logic [7:0] exp_ack(input logic [15:0] frame, input logic [15:0] slv);
`ifdef SPI_3WIRE_EN
        if (!frame[15]) return frame[7:0];
`endif
        return slv[7:0];
    endfunction

    // Advance one cycle; sample pins at the falling clk edge and play slave.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (prev_cs && !spi_cs_n) begin
            gap_at_fall = cs_high_run;
            fall_cyc    = cyc;
            rise_cnt    = 0;
            fall_cnt    = 0;
            miso_idx    = 0;
            cs_low_cnt  = 0;
            oe_fall_num = 0;
            oe_rise_cyc = -1;
        end
        if (spi_cs_n) cs_high_run++;
        else begin
            cs_high_run = 0;
            cs_low_cnt++;
        end
        if (spi_sclk !== prev_sclk) sclk_edges++;
        if (!prev_sclk && spi_sclk) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[14:0], spi_mosi};
        end
        if (prev_sclk && !spi_sclk && !spi_cs_n) begin
            fall_cnt++;
            if (miso_idx < 16) begin
                spi_miso = slave_word[15-miso_idx];
                miso_idx++;
            end
        end
`ifdef SPI_3WIRE_EN
        if (prev_oe && !spi_mosi_oe) oe_fall_num = fall_cnt;
        if (!prev_oe && spi_mosi_oe) oe_rise_cyc = cyc;
        if (spi_mosi_oe) spi_miso = spi_mosi;
        prev_oe = spi_mosi_oe;
`endif
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs_n;
    endtask

    // One full frame. With t0_known the request is raised here (T0 = now);
    // otherwise it was left raised by a previous chained frame.
    task automatic run_one(input logic [15:0] frame, input logic [15:0] slv,
                           input bit chain, input logic [15:0] nxt, input bit t0_known);
        int   t0;
        int   ack_cyc;
        bit   got;
        logic [7:0] exp;
        t0 = cyc;
        if (t0_known) begin
            host_req      = 1'b1;
            host_req_data = frame;
        end
        slave_word = slv;
        exp_q.push_back(exp_ack(frame, slv));
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!spi_cs_n) host_req_data = 16'($urandom);
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_seen", got, 1);
        ack_cyc = cyc;
        if (t0_known) check("ack_latency_t0", ack_cyc - t0, LAT);
        else check("gap_ge_cs_idle", gap_at_fall >= CS_IDLE, 1);
        check("ack_after_cs_fall", ack_cyc - fall_cyc, LAT - 1);
        check("sclk_rises", rise_cnt, 16);
        check("mosi_stream", mosi_cap, frame);
        check("cs_low_cycles", cs_low_cnt, LAT - 1);
        exp = exp_q.pop_front();
        check("ack_data", host_ack_data, exp);
`ifdef SPI_3WIRE_EN
        if (frame[15]) begin
            check("oe_fall_9th", oe_fall_num, 9);
            check("oe_rise_ack", oe_rise_cyc, ack_cyc);
        end else begin
            check("oe_write_high", oe_fall_num, 0);
        end
`endif
        if (chain) host_req_data = nxt;
        tick();
        check("ack_one_cycle", host_ack, 0);
        check("ack_data_held", host_ack_data, exp);
        if (!chain) begin
            // Request still high one cycle after the ack: must not restart.
            tick();
            host_req = 1'b0;
            for (int i = 0; i < CS_IDLE + 3; i++) begin
                tick();
                check("no_restart_cs", spi_cs_n, 1);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ack_seen;
        bit hit;
        rst           = 1'b1;
        host_req      = 1'b0;
        host_req_data = '0;
        spi_miso      = 1'b0;
        repeat (3) tick();
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sclk", spi_sclk, 1);
        check("rst_mosi", spi_mosi, 0);
        check("rst_ack", host_ack, 0);
        check("rst_ack_data", host_ack_data, 0);
`ifdef SPI_3WIRE_EN
        check("rst_oe", spi_mosi_oe, 1);
`endif
        rst = 1'b0;
        sclk_edges = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_cs_n", spi_cs_n, 1);
            check("idle_sclk", spi_sclk, 1);
            check("idle_ack", host_ack, 0);
        end
        check("idle_sclk_edges", sclk_edges, 0);

        // Read of register 0x32 with the slave answering 0x5A.
        run_one(16'hB200, {8'($urandom), 8'h5A}, 1'b0, 16'h0, 1'b1);
        // Write 0x28 to register 0x2D.
        run_one(16'h2D28, 16'($urandom), 1'b0, 16'h0, 1'b1);

        // Back-to-back reads, second request raised in the ack cycle.
        run_one(16'hB200, 16'h00C3, 1'b1, 16'hB300, 1'b1);
        run_one(16'hB300, 16'h003C, 1'b0, 16'h0, 1'b0);

        // Reset landing at bit 7 of a frame.
        host_req      = 1'b1;
        host_req_data = 16'hB500;
        slave_word    = 16'hFFFF;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!spi_cs_n && rise_cnt == 7) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_bit7", hit, 1);
        rst      = 1'b1;
        host_req = 1'b0;
        tick();
        check("midrst_cs_n", spi_cs_n, 1);
        check("midrst_sclk", spi_sclk, 1);
        check("midrst_ack", host_ack, 0);
        check("midrst_ack_data", host_ack_data, 0);
        check("midrst_mosi", spi_mosi, 0);
        rst = 1'b0;
        ack_seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (host_ack) ack_seen++;
        end
        check("midrst_no_ack", ack_seen, 0);
        run_one(16'hB600, 16'h0081, 1'b0, 16'h0, 1'b1);

`ifdef SPI_3WIRE_EN
        run_one(16'hB400, 16'h00A5, 1'b0, 16'h0, 1'b1);
`endif

        // Randomized frames with random idle spacing.
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 5)) tick();
            run_one(16'($urandom), 16'($urandom), 1'b0, 16'h0, 1'b1);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
